fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 5, exponent field width (legal 4..8).
REQ-002 Parameter MAN_W, default 10, stored mantissa width (legal 3..23); the defaults give IEEE binary16.
REQ-003 Port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, the operand beat is valid.
REQ-006 Port in_ready, output, 1, the block accepts the beat this cycle.
REQ-007 Port data1, input, 1+EXP_W+MAN_W, operand A as {sign, exp, mantissa}.
REQ-008 Port data2, input, 1+EXP_W+MAN_W, operand B.
REQ-009 Port sub, input, 1, operation select: 0 gives A+B, 1 gives A-B (B sign inverted at acceptance).
REQ-010 Port out_valid, output, 1, the result beat is valid.
REQ-011 Port out_ready, input, 1, downstream accepts the result.
REQ-012 Port result, output, 1+EXP_W+MAN_W, the rounded sum.
REQ-013 Port flags, output, 3, {invalid, overflow, inexact} for the current result.

Function
REQ-014 The block SHALL be a 3-stage pipeline:
  - S1: unpack, swap by magnitude, align (shift right with sticky).
  - S2: add/subtract, leading-zero count, normalise.
  - S3: round-to-nearest-even, pack, flags.
REQ-015 A beat SHALL be accepted when in_valid && in_ready.
REQ-016 Latency SHALL be 3 cycles from acceptance to out_valid when there is no backpressure.
REQ-017 Throughput SHALL be 1 beat per cycle.
REQ-018 Each stage register SHALL load when it is empty or its content advances in the same cycle.
REQ-019 in_ready SHALL equal !S1_valid || S1_advance, and SHALL be combinational with no dependency on in_valid.
REQ-020 While out_valid && !out_ready, result and flags SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-021 A full pipeline under stall SHALL hold 3 beats; when out_ready rises, the beats SHALL drain in order, 1 per cycle.
REQ-022 Subnormal inputs SHALL use effective exponent 1 with hidden bit 0; subnormal results SHALL be produced without flushing to zero.
REQ-023 The alignment shift SHALL saturate at MAN_W+3; bits shifted out SHALL be ORed into a sticky bit.
REQ-024 Rounding SHALL use guard, round and sticky bits, round-to-nearest ties-to-even; rounding carry-out SHALL increment the exponent.
REQ-025 Exact cancellation (x + (-x)) SHALL give +0.
REQ-026 A zero operand SHALL pass the other operand through unchanged; -0 + -0 SHALL give -0.
REQ-027 Any NaN input SHALL give canonical qNaN {0, all-ones exp, 1 followed by zeros} with invalid=1.
REQ-028 Inf + (-Inf) after the sub inversion SHALL give canonical qNaN with invalid=1.
REQ-029 Inf combined with a finite operand SHALL give that Inf, with flags 0.
REQ-030 inexact SHALL be set when any of guard, round or sticky is nonzero, or when the result overflows.
REQ-031 Overflow SHALL set overflow=1 and inexact=1; the encoding is set by REQ-037.

Reset
REQ-032 While rst_n=0, all stage valid bits SHALL clear to 0 immediately without waiting for clk.
REQ-033 During reset: out_valid=0, result=0, flags=0, in_ready=1.
REQ-034 Beats in flight when reset asserts SHALL be discarded; no partial result SHALL appear after release.
REQ-035 The first beat after reset release SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-036 Macro FP_ADD_SAT_EN SHALL select the overflow encoding.
REQ-037 Overflow result by build:
  - Defined: saturate to the maximum finite value {sign, all-ones-minus-1 exp, all-ones mantissa}.
  - Undefined: signed infinity {sign, all-ones exp, 0}.
  - The overflow flag is set identically in both builds.

Verification
REQ-038 Defaults, out_ready=1: 0x3C00+0x3C00, sub=0 -> result 0x4000, flags 000, out_valid exactly 3 cycles after acceptance.
REQ-039 0x7BFF+0x7BFF -> 0x7BFF with FP_ADD_SAT_EN, 0x7C00 without; flags 011 in both builds.
REQ-040 0x3C00 and 0x3C00 with sub=1 -> 0x0000, flags 000.
REQ-041 0x0001+0x0001 -> 0x0002; 0x3C00+0x1000 (tie) -> 0x3C00, flags 001.
REQ-042 0x7C00+0xFC00 -> 0x7E00, flags 100; 0x7E01+0x3C00 -> 0x7E00, flags 100.
REQ-043 Backpressure: stream 5 beats with out_ready low for 4 cycles.
  - in_ready drops after 3 accepted beats.
  - All 5 results emerge in order with no loss or duplication.
  - Asserting rst_n=0 mid-stream clears out_valid immediately.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Define FP_ADD_SAT_EN to saturate overflow to the largest finite value instead of infinity.
module fp_addsub_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   data1,
   input  logic [EXP_W+MAN_W:0]   data2,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [2:0]             flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int XW = MAN_W + 4;   // hidden bit + mantissa + guard/round/sticky
   localparam int EW = EXP_W + 1;   // exponent with headroom for carry-out
   localparam int PW = EW + MAN_W;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic [EW-1:0] lzc(input logic [XW-1:0] v);
      logic [EW-1:0] n;
      logic          found;
      n = EW'(XW);
      found = 1'b0;
      for (int i = XW-1; i >= 0; i--) begin
         if (v[i] && !found) begin
            n = EW'(XW-1-i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   function automatic logic rnd_up(input logic lsb, input logic g, input logic r, input logic s);
      return g & (r | s | lsb);
   endfunction

   function automatic logic [W-1:0] ovf_value(input logic sgn);
`ifdef FP_ADD_SAT_EN
      return {sgn, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
`else
      return {sgn, EXP_ONES, {MAN_W{1'b0}}};
`endif
   endfunction

   logic vld_p0, vld_p1, vld_p2;
   logic load_p0, load_p1, load_p2;

   assign load_p2   = !vld_p2 || out_ready;
   assign load_p1   = !vld_p1 || load_p2;
   assign load_p0   = !vld_p0 || load_p1;
   assign in_ready  = load_p0;
   assign out_valid = vld_p2;

   // ---- S1: unpack, special cases, swap by magnitude, align ----
   logic [W-1:0]     opa, opb;
   logic             sa, sb, big_s, swap;
   logic [EXP_W-1:0] ea, eb, big_e, sml_e, be, se;
   logic [MAN_W-1:0] ma, mb, big_m, sml_m;
   logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic [7:0]       diff8, sh8;
   logic [XW-1:0]    big_x, sml_x, mask, aligned;
   logic             spc_w, spc_inv_w;
   logic [W-1:0]     spc_res_w;

   assign opa = data1;
   assign opb = {data2[W-1] ^ sub, data2[W-2:0]};
   assign {sa, ea, ma} = opa;
   assign {sb, eb, mb} = opb;

   assign nan_a  = (ea == EXP_ONES) && (ma != '0);
   assign nan_b  = (eb == EXP_ONES) && (mb != '0);
   assign inf_a  = (ea == EXP_ONES) && (ma == '0);
   assign inf_b  = (eb == EXP_ONES) && (mb == '0);
   assign zero_a = (ea == '0) && (ma == '0);
   assign zero_b = (eb == '0) && (mb == '0);

   assign swap = opb[W-2:0] > opa[W-2:0];
   assign {big_s, big_e, big_m} = swap ? opb : opa;
   assign {sml_e, sml_m}        = swap ? opa[W-2:0] : opb[W-2:0];

   // subnormals use effective exponent 1 with a zero hidden bit
   assign be    = (big_e == '0) ? EXP_W'(1) : big_e;
   assign se    = (sml_e == '0) ? EXP_W'(1) : sml_e;
   assign big_x = {big_e != '0, big_m, 3'b000};
   assign sml_x = {sml_e != '0, sml_m, 3'b000};
   assign diff8 = 8'(be) - 8'(se);
   assign sh8   = (diff8 > 8'(XW-1)) ? 8'(XW-1) : diff8;
   assign mask  = (XW'(1) << sh8) - XW'(1);
   assign aligned = (sml_x >> sh8) | {{(XW-1){1'b0}}, |(sml_x & mask)};

   always_comb begin
      spc_w     = 1'b1;
      spc_inv_w = 1'b0;
      spc_res_w = QNAN;
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) spc_inv_w = 1'b1;
      else if (inf_a)              spc_res_w = opa;
      else if (inf_b)              spc_res_w = opb;
      else if (zero_a && zero_b)   spc_res_w = {sa & sb, {(W-1){1'b0}}};
      else if (zero_a)             spc_res_w = opb;
      else if (zero_b)             spc_res_w = opa;
      else                         spc_w = 1'b0;
   end

   logic             spc_p0, spc_inv_p0, sign_p0, esub_p0;
   logic [W-1:0]     spc_res_p0;
   logic [EXP_W-1:0] exp_p0;
   logic [XW-1:0]    big_p0, sml_p0;

   always_ff @(posedge clk) begin
      if (in_valid && load_p0) begin
         spc_p0     <= spc_w;
         spc_inv_p0 <= spc_inv_w;
         spc_res_p0 <= spc_res_w;
         sign_p0    <= big_s;
         esub_p0    <= sa ^ sb;
         exp_p0     <= be;
         big_p0     <= big_x;
         sml_p0     <= aligned;
      end
   end

   // ---- S2: add/subtract, leading-zero count, normalise ----
   logic [XW:0]   sum_w;
   logic [XW-1:0] norm_w;
   logic [EW-1:0] nexp_w, lz_w, lsh_w, emax_w;

   always_comb begin
      sum_w  = esub_p0 ? ({1'b0, big_p0} - {1'b0, sml_p0}) : ({1'b0, big_p0} + {1'b0, sml_p0});
      lz_w   = lzc(sum_w[XW-1:0]);
      emax_w = EW'(exp_p0) - EW'(1);
      lsh_w  = (lz_w < emax_w) ? lz_w : emax_w;
      if (sum_w[XW]) begin
         norm_w = {sum_w[XW:2], sum_w[1] | sum_w[0]};
         nexp_w = EW'(exp_p0) + EW'(1);
      end else begin
         // left shift stops at exponent 1 so tiny results stay subnormal
         norm_w = sum_w[XW-1:0] << lsh_w;
         nexp_w = norm_w[XW-1] ? (EW'(exp_p0) - lsh_w) : '0;
      end
   end

   logic          spc_p1, spc_inv_p1, sign_p1;
   logic [W-1:0]  spc_res_p1;
   logic [EW-1:0] exp_p1;
   logic [XW-1:0] man_p1;

   always_ff @(posedge clk) begin
      if (vld_p0 && load_p1) begin
         spc_p1     <= spc_p0;
         spc_inv_p1 <= spc_inv_p0;
         spc_res_p1 <= spc_res_p0;
         sign_p1    <= sign_p0 & (sum_w != '0);
         exp_p1     <= nexp_w;
         man_p1     <= norm_w;
      end
   end

   // ---- S3: round to nearest even, pack, flags ----
   logic          up_w, ovf_w, inx_w;
   logic [PW-1:0] packed_w;

   // rounding carry ripples from the mantissa field straight into the exponent
   assign up_w     = rnd_up(man_p1[3], man_p1[2], man_p1[1], man_p1[0]);
   assign packed_w = {exp_p1, man_p1[XW-2:3]} + PW'(up_w);
   assign ovf_w    = packed_w[PW-1:MAN_W] >= EW'(EXP_ONES);
   assign inx_w    = (|man_p1[2:0]) | ovf_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else begin
         if (load_p0) vld_p0 <= in_valid;
         if (load_p1) vld_p1 <= vld_p0;
         if (load_p2) vld_p2 <= vld_p1;
         if (load_p2 && vld_p1) begin
            if (spc_p1) begin
               result <= spc_res_p1;
               flags  <= {spc_inv_p1, 2'b00};
            end else if (ovf_w) begin
               result <= ovf_value(sign_p1);
               flags  <= 3'b011;
            end else begin
               result <= {sign_p1, packed_w[EXP_W+MAN_W-1:0]};
               flags  <= {2'b00, inx_w};
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors for the binary16 build, checked against an exact-arithmetic model.
module tb_fp_addsub_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] data1 = '0;
   logic [15:0] data2 = '0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic [2:0]  flags;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int acc_cnt = 0;
   int out_cnt = 0;

`ifdef FP_ADD_SAT_EN
   localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
   localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data1(data1), .data2(data2), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Exact value in units of 2^-24 (the smallest subnormal)
   function automatic longint fp_val(input logic [15:0] x);
      int     f, mm;
      longint m;
      f  = int'(x[14:10]);
      mm = int'(x[9:0]);
      if (f == 0) m = longint'(mm);
      else        m = longint'(1024 + mm) << (f - 1);
      return x[15] ? -m : m;
   endfunction

   // Returns {flags, result}
   function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b0, input logic s);
      logic [15:0] b;
      logic        a_nan, b_nan, a_inf, b_inf, sg;
      longint      sum, mag, q, rem, half, enc;
      int          k;
      b     = {b0[15] ^ s, b0[14:0]};
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
      if (a_nan || b_nan) return {3'b100, 16'h7E00};
      if (a_inf && b_inf && (a[15] != b[15])) return {3'b100, 16'h7E00};
      if (a_inf) return {3'b000, a};
      if (b_inf) return {3'b000, b};
      sum = fp_val(a) + fp_val(b);
      if (sum == 0) begin
         if (a == 16'h8000 && b == 16'h8000) return {3'b000, 16'h8000};
         return {3'b000, 16'h0000};
      end
      sg  = (sum < 0);
      mag = sg ? -sum : sum;
      k   = 0;
      while ((mag >> k) >= 2048) k++;
      q   = mag >> k;
      rem = mag - (q << k);
      if (k > 0) begin
         half = longint'(1) << (k - 1);
         if (rem > half || (rem == half && (q % 2) == 1)) q++;
      end
      enc = longint'(k) * 1024 + q;
      if (enc >= 64'h7C00) return {3'b011, sg, OVF_MAG};
      return {2'b00, rem != 0, sg, enc[14:0]};
   endfunction

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [15:0] r;
      logic [2:0]  f;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   logic [18:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_res = '0;
   logic [2:0]  prev_flg = '0;

   always @(negedge clk) begin
      logic [18:0] e;
      if (!rst_n) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_result", result, 0);
         check("rst_flags", flags, 0);
         check("rst_in_ready", in_ready, 1);
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", {flags, result}, {prev_flg, prev_res});
         end
         if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("dut_beat", {flags, result}, e);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(data1, data2, sub));
            acc_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = result;
         prev_flg   = flags;
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, output int tries);
      logic got;
      data1 = a; data2 = b; sub = s; in_valid = 1'b1;
      tries = 0;
      got = 1'b0;
      while (!got && tries < 200) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end
      in_valid = 1'b0;
      check("send_accept", got, 1);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int t, lat, acc0, out0;
      vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000};
      vecs[1]  = '{16'h7BFF, 16'h7BFF, 1'b0, {1'b0, OVF_MAG}, 3'b011};
      vecs[2]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000};
      vecs[3]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000};
      vecs[4]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001};
      vecs[5]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100};
      vecs[6]  = '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b100};
      vecs[7]  = '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 3'b001};
      vecs[8]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001};
      vecs[9]  = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000};
      vecs[10] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 3'b100};
      vecs[11] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b000};
      vecs[12] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 3'b000};
      vecs[13] = '{16'h0000, 16'hBC00, 1'b0, 16'hBC00, 3'b000};
      vecs[14] = '{16'h3C00, 16'h3800, 1'b1, 16'h3800, 3'b000};
      vecs[15] = '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 3'b000};
      vecs[16] = '{16'h4000, 16'hBC00, 1'b0, 16'h3C00, 3'b000};
      vecs[17] = '{16'h7BFF, 16'h5000, 1'b0, {1'b0, OVF_MAG}, 3'b011};
      vecs[18] = '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b001};
      vecs[19] = '{16'h3C00, 16'h0001, 1'b1, 16'h3C00, 3'b001};
      vecs[20] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000};
      vecs[21] = '{16'hFBFF, 16'hFBFF, 1'b0, {1'b1, OVF_MAG}, 3'b011};
      vecs[22] = '{16'h3555, 16'h3555, 1'b0, 16'h3955, 3'b000};
      vecs[23] = '{16'h0200, 16'h0200, 1'b0, 16'h0400, 3'b000};

      // hand-computed values pin the model
      for (int i = 0; i < NV; i++)
         check($sformatf("model_pin_%0d", i), model(vecs[i].a, vecs[i].b, vecs[i].s), {vecs[i].f, vecs[i].r});

      #1;
      check("init_out_valid", out_valid, 0);
      check("init_result", result, 0);
      check("init_in_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single beat latency
      data1 = 16'h3C00; data2 = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("first_accept", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (out_valid && lat == 0) lat = i;
      end
      check("latency", lat, 3);
      @(posedge clk);
      #1;

      // back-to-back stream
      acc0 = acc_cnt;
      for (int i = 0; i < NV; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].s, t);
         check($sformatf("stream_tries_%0d", i), t, 1);
      end
      check("stream_accepts", acc_cnt - acc0, NV);
      wait_drain("stream_drain");

      // backpressure: out_ready low for 4 cycles while 5 beats are offered
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      acc0 = acc_cnt;
      out0 = out_cnt;
      fork
         begin
            int tt;
            for (int i = 0; i < 5; i++) send(vecs[14+i].a, vecs[14+i].b, vecs[14+i].s, tt);
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_accepted_3", acc_cnt - acc0, 3);
            check("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain("bp_drain");
      check("bp_out_count", out_cnt - out0, 5);

      // reset asserted with a full, stalled pipeline
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(vecs[4+i].a, vecs[4+i].b, vecs[4+i].s, t);
      #1;
      check("prerst_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_result", result, 0);
      check("async_rst_flags", flags, 0);
      check("async_rst_in_ready", in_ready, 1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_quiet", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(16'h3C00, 16'h3800, 1'b0, t);
      check("post_rst_first_try", t, 1);
      wait_drain("final_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
